// File: rtl/xilinx_sdp_ram_pipelined_pkg.sv
// Shared definitions for the simple-dual-port pipelined RAM: address-width math
// and read-during-write mode encodings.
package xilinx_sdp_ram_pipelined_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Ceiling log2, clamped to 1 so a single-word RAM still gets a 1-bit address.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/xilinx_sdp_ram_pipelined_if.sv
// Write port, read request and read response signals of the pipelined SDP RAM.
interface xilinx_sdp_ram_pipelined_if #(
  parameter int C_RAM_WIDTH = 64,
  parameter int C_RAM_DEPTH = 512
);
  import xilinx_sdp_ram_pipelined_pkg::*;

  localparam int AW = clog2(C_RAM_DEPTH);
  localparam int BW = C_RAM_WIDTH / 8;

  logic [AW-1:0]          wrAddr;
  logic                   wren;
  logic [BW-1:0]          wrBe;
  logic [C_RAM_WIDTH-1:0] datain;
  logic [AW-1:0]          rdAddr;
  logic                   rden;
  logic [C_RAM_WIDTH-1:0] dataout;
  logic                   dataout_valid;

  modport master (
    output wrAddr, wren, wrBe, datain, rdAddr, rden,
    input  dataout, dataout_valid
  );

  modport slave (
    input  wrAddr, wren, wrBe, datain, rdAddr, rden,
    output dataout, dataout_valid
  );

endinterface

// File: rtl/xilinx_sdp_ram_pipelined_sdp_rd_pipe.sv
// Valid/data delay line: a valid shift chain with data stages that load only
// when the valid entering them is set, so the last stage holds its last word.
module sdp_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] data_p [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else begin
      // stage 0 captures the request; later stages follow the valid chain
      vld_p[0] <= vld_in;
      if (vld_in) data_p[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign data_out = data_p[STAGES-1];

endmodule

// File: rtl/xilinx_sdp_ram_pipelined.sv
// Simple-dual-port RAM with byte-write enables, selectable read-during-write
// behaviour and a fixed-latency, non-stalling read pipeline.
module xilinx_sdp_ram_pipelined
  import xilinx_sdp_ram_pipelined_pkg::*;
#(
  parameter int C_RAM_WIDTH  = 64,
  parameter int C_RAM_DEPTH  = 512,
  parameter int C_RD_LATENCY = 3,
  parameter int C_RDW_MODE   = 0
) (
  input logic clk,
  input logic rst,
  xilinx_sdp_ram_pipelined_if.slave bus
);

  localparam int AW = clog2(C_RAM_DEPTH);
  localparam int BW = C_RAM_WIDTH / 8;
  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(C_RAM_DEPTH);

  logic [C_RAM_WIDTH-1:0] mem [C_RAM_DEPTH];

  logic                   wr_ok;
  logic                   rd_ok;
  logic                   wr_hit;
  logic [C_RAM_WIDTH-1:0] be_mask;
  logic [C_RAM_WIDTH-1:0] rd_word;
  logic                   rd_vld;

  assign wr_ok  = bus.wren && !rst && ({1'b0, bus.wrAddr} < DEPTH_EXT);
  assign rd_ok  = {1'b0, bus.rdAddr} < DEPTH_EXT;
  assign wr_hit = wr_ok && (bus.wrAddr == bus.rdAddr);
  assign rd_vld = bus.rden && !rst;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BW; b++) be_mask[8*b +: 8] = {8{bus.wrBe[b]}};
  end

  // Array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < BW; b++) begin
        if (bus.wrBe[b]) mem[bus.wrAddr][8*b +: 8] <= bus.datain[8*b +: 8];
      end
    end
  end

  // Write-first merges the incoming bytes over the stored word on a collision.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.rdAddr];
      if ((C_RDW_MODE == RDW_WRITE_FIRST) && wr_hit)
        rd_word = (rd_word & ~be_mask) | (bus.datain & be_mask);
    end
  end

  sdp_rd_pipe #(
    .DATA_W (C_RAM_WIDTH),
    .STAGES (C_RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (rd_vld),
    .data_in  (rd_word),
    .vld_out  (bus.dataout_valid),
    .data_out (bus.dataout)
  );

endmodule
